// File: rtl/vram_write_sequencer_if.sv
// Write-command handshake between the CPU bus-cycle decoder (master)
// and the VRAM write sequencer (slave).
interface vram_write_sequencer_if;
    logic        req_valid;
    logic [2:0]  req_port;
    logic [23:0] req_data;
    logic        req_ready;

    modport master (
        output req_valid,
        output req_port,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_port,
        input  req_data,
        output req_ready
    );
endinterface

// File: rtl/vram_write_sequencer.sv
// Buffers decoded I/O write commands and replays them as timed write cycles
// on an asynchronous 16-bit VRAM, with an auto-incrementing word pointer.
module vram_write_sequencer #(
    parameter int DEPTH     = 4,
    parameter int WE_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    vram_write_sequencer_if.slave req,
    output logic                  busy,
    output logic                  VRAM_CSb,
    output logic                  VRAM_WEb,
    output logic                  VRAM_OEb,
    output logic                  VRAM_UBb,
    output logic                  VRAM_LBb,
    output logic [17:0]           VRAM_addr,
    output logic [15:0]           VRAM_dat_o,
    output logic                  VRAM_dat_oe
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;

    localparam logic [2:0] PORT_SETPTR = 3'd3;
    localparam logic [2:0] PORT_WRITE  = 3'd5;
    localparam logic [2:0] PORT_FILL   = 3'd6;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD
    } state_t;

    // Active-high {upper, lower} select to active-low {UBb, LBb}; 2'b00 means both lanes.
    function automatic logic [1:0] lane_enables_n(input logic [1:0] sel);
        logic [1:0] en_n;
        if (sel == 2'b00) begin
            en_n = 2'b00;
        end else begin
            en_n = ~sel;
        end
        return en_n;
    endfunction

    logic [26:0]   fifo_mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic [26:0]   head;
    logic [2:0]    head_port;
    logic [23:0]   head_data;
    logic [1:0]    head_lanes_n;
    logic          unused_head_hi;

    state_t        state;
    logic [CW-1:0] we_cnt;
    logic [7:0]    fill_rem;
    logic [17:0]   pointer;
    logic [15:0]   fill_val;

    // FIFO status is derived from registered pointers only, so a pop in the
    // same cycle never frees a slot for a push into a full FIFO.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                        (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign push = req.req_valid && !fifo_full;
    assign pop  = (state == IDLE) && !fifo_empty;

    assign req.req_ready = !fifo_full;
    assign busy          = !fifo_empty || (state != IDLE);
    assign VRAM_OEb      = 1'b1;

    assign head           = fifo_mem[rd_ptr[AW-1:0]];
    assign head_port      = head[26:24];
    assign head_data      = head[23:0];
    assign head_lanes_n   = lane_enables_n(head_data[17:16]);
    assign unused_head_hi = ^head_data[23:18];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr[AW-1:0]] <= {req.req_port, req.req_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    // Write-cycle FSM: IDLE pops, SETUP -> STROBE x WE_CYCLES -> HOLD per word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            we_cnt      <= '0;
            fill_rem    <= '0;
            pointer     <= '0;
            fill_val    <= '0;
            VRAM_CSb    <= 1'b1;
            VRAM_WEb    <= 1'b1;
            VRAM_UBb    <= 1'b1;
            VRAM_LBb    <= 1'b1;
            VRAM_addr   <= '0;
            VRAM_dat_o  <= '0;
            VRAM_dat_oe <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        case (head_port)
                            PORT_SETPTR: begin
                                pointer <= head_data[17:0];
                            end
                            PORT_WRITE: begin
                                fill_val    <= head_data[15:0];
                                fill_rem    <= '0;
                                VRAM_addr   <= pointer;
                                VRAM_dat_o  <= head_data[15:0];
                                VRAM_UBb    <= head_lanes_n[1];
                                VRAM_LBb    <= head_lanes_n[0];
                                VRAM_CSb    <= 1'b0;
                                VRAM_WEb    <= 1'b1;
                                VRAM_dat_oe <= 1'b1;
                                state       <= SETUP;
                            end
                            PORT_FILL: begin
                                fill_rem    <= head_data[7:0];
                                VRAM_addr   <= pointer;
                                VRAM_dat_o  <= fill_val;
                                VRAM_UBb    <= 1'b0;
                                VRAM_LBb    <= 1'b0;
                                VRAM_CSb    <= 1'b0;
                                VRAM_WEb    <= 1'b1;
                                VRAM_dat_oe <= 1'b1;
                                state       <= SETUP;
                            end
                            default: begin
                            end
                        endcase
                    end
                end
                SETUP: begin
                    VRAM_WEb <= 1'b0;
                    we_cnt   <= CW'(WE_CYCLES - 1);
                    state    <= STROBE;
                end
                STROBE: begin
                    if (we_cnt == '0) begin
                        VRAM_WEb <= 1'b1;
                        state    <= HOLD;
                    end else begin
                        we_cnt <= we_cnt - CW'(1);
                    end
                end
                HOLD: begin
                    pointer <= pointer + 18'd1;
                    if (fill_rem != '0) begin
                        fill_rem  <= fill_rem - 8'd1;
                        VRAM_addr <= pointer + 18'd1;
                        state     <= SETUP;
                    end else begin
                        VRAM_CSb    <= 1'b1;
                        VRAM_UBb    <= 1'b1;
                        VRAM_LBb    <= 1'b1;
                        VRAM_dat_oe <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vram_write_sequencer.sv
// Scoreboard bench for vram_write_sequencer: directed commands push expected
// VRAM writes; a negedge monitor pops and checks each observed write cycle.
module tb_vram_write_sequencer;

    localparam int WE_CYCLES = 2;

    typedef struct {
        logic [17:0] addr;
        logic [15:0] dat;
        logic        ub_n;
        logic        lb_n;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        busy;
    logic        VRAM_CSb, VRAM_WEb, VRAM_OEb, VRAM_UBb, VRAM_LBb, VRAM_dat_oe;
    logic [17:0] VRAM_addr;
    logic [15:0] VRAM_dat_o;

    vram_write_sequencer_if req_if ();

    vram_write_sequencer #(
        .DEPTH     (4),
        .WE_CYCLES (WE_CYCLES)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req_if),
        .busy        (busy),
        .VRAM_CSb    (VRAM_CSb),
        .VRAM_WEb    (VRAM_WEb),
        .VRAM_OEb    (VRAM_OEb),
        .VRAM_UBb    (VRAM_UBb),
        .VRAM_LBb    (VRAM_LBb),
        .VRAM_addr   (VRAM_addr),
        .VRAM_dat_o  (VRAM_dat_o),
        .VRAM_dat_oe (VRAM_dat_oe)
    );

    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    int   nwrites  = 0;
    bit   abort    = 1'b0;
    bit   saw_not_ready = 1'b0;
    exp_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    task automatic expect_write(input logic [17:0] a, input logic [15:0] d,
                                input logic ub_n, input logic lb_n);
        exp_t e;
        e.addr = a;
        e.dat  = d;
        e.ub_n = ub_n;
        e.lb_n = lb_n;
        exp_q.push_back(e);
    endtask

    task automatic send(input logic [2:0] port, input logic [23:0] data);
        int n;
        @(negedge clk);
        req_if.req_valid = 1'b1;
        req_if.req_port  = port;
        req_if.req_data  = data;
        n = 0;
        while (!req_if.req_ready && n < 500) begin
            saw_not_ready = 1'b1;
            @(negedge clk);
            n++;
        end
        if (n >= 500) chk("send_timeout", 32'(n), 32'd0);
        @(posedge clk);
    endtask

    task automatic wait_idle(input string name, input logic [17:0] last_addr,
                             input logic [15:0] last_dat);
        int n;
        @(negedge clk);
        req_if.req_valid = 1'b0;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (busy && n < 3000);
        chk({name, "_idle_timeout"}, 32'(busy), 32'd0);
        chk({name, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
        chk({name, "_csb_idle"}, 32'(VRAM_CSb), 32'd1);
        chk({name, "_oe_idle"}, 32'(VRAM_dat_oe), 32'd0);
        chk({name, "_addr_held"}, 32'(VRAM_addr), 32'(last_addr));
        chk({name, "_dat_held"}, 32'(VRAM_dat_o), 32'(last_dat));
    endtask

    // Monitor: every WEb falling edge is one VRAM write and must match the queue head.
    logic prev_web = 1'b1;
    logic prev_csb = 1'b1;
    int   low_cnt  = 0;
    exp_t cur;

    always @(negedge clk) begin
        if (prev_web && !VRAM_WEb) begin
            nwrites++;
            low_cnt = 1;
            chk("setup_cs_low", 32'(prev_csb), 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: got addr %h dat %h, want no write",
                         VRAM_addr, VRAM_dat_o);
            end else begin
                cur = exp_q.pop_front();
                chk("wr_addr", 32'(VRAM_addr), 32'(cur.addr));
                chk("wr_dat", 32'(VRAM_dat_o), 32'(cur.dat));
                chk("wr_ubb", 32'(VRAM_UBb), 32'(cur.ub_n));
                chk("wr_lbb", 32'(VRAM_LBb), 32'(cur.lb_n));
                chk("wr_csb", 32'(VRAM_CSb), 32'd0);
                chk("wr_oe", 32'(VRAM_dat_oe), 32'd1);
            end
        end else if (!VRAM_WEb) begin
            low_cnt++;
            chk("strobe_addr_stable", 32'(VRAM_addr), 32'(cur.addr));
            chk("strobe_dat_stable", 32'(VRAM_dat_o), 32'(cur.dat));
        end else if (!prev_web && !abort) begin
            chk("we_low_cycles", 32'(low_cnt), 32'(WE_CYCLES));
            chk("hold_csb", 32'(VRAM_CSb), 32'd0);
            chk("hold_addr", 32'(VRAM_addr), 32'(cur.addr));
            chk("hold_dat", 32'(VRAM_dat_o), 32'(cur.dat));
            chk("hold_busy", 32'(busy), 32'd1);
        end
        chk("oeb_high", 32'(VRAM_OEb), 32'd1);
        prev_web = VRAM_WEb;
        prev_csb = VRAM_CSb;
    end

    initial begin
        int n;
        int wr_before;
        req_if.req_valid = 1'b0;
        req_if.req_port  = '0;
        req_if.req_data  = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_csb", 32'(VRAM_CSb), 32'd1);
        chk("rst_web", 32'(VRAM_WEb), 32'd1);
        chk("rst_oeb", 32'(VRAM_OEb), 32'd1);
        chk("rst_ubb", 32'(VRAM_UBb), 32'd1);
        chk("rst_lbb", 32'(VRAM_LBb), 32'd1);
        chk("rst_addr", 32'(VRAM_addr), 32'd0);
        chk("rst_dat", 32'(VRAM_dat_o), 32'd0);
        chk("rst_oe", 32'(VRAM_dat_oe), 32'd0);
        chk("rst_ready", 32'(req_if.req_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Basic write after SETPTR, then lane selection with the incremented pointer.
        expect_write(18'h00010, 16'hA329, 1'b0, 1'b0);
        send(3'd3, 24'h000010);
        send(3'd5, 24'hF7A329);
        wait_idle("write", 18'h00010, 16'hA329);
        expect_write(18'h00011, 16'h00FF, 1'b1, 1'b0);
        send(3'd5, 24'h0100FF);
        wait_idle("lane_lo", 18'h00011, 16'h00FF);
        expect_write(18'h00012, 16'h00FF, 1'b0, 1'b1);
        send(3'd5, 24'h0200FF);
        wait_idle("lane_hi", 18'h00012, 16'h00FF);

        // Fill across the pointer wrap; discarded ports must not move the pointer.
        expect_write(18'h3FFFE, 16'h00FF, 1'b0, 1'b0);
        expect_write(18'h3FFFF, 16'h00FF, 1'b0, 1'b0);
        expect_write(18'h00000, 16'h00FF, 1'b0, 1'b0);
        expect_write(18'h00001, 16'h00FF, 1'b0, 1'b0);
        send(3'd3, 24'h03FFFE);
        send(3'd5, 24'h0000FF);
        send(3'd6, 24'h000002);
        wait_idle("fill", 18'h00001, 16'h00FF);
        expect_write(18'h00002, 16'h1234, 1'b0, 1'b0);
        send(3'd7, 24'h123456);
        send(3'd0, 24'hABCDEF);
        send(3'd5, 24'h001234);
        wait_idle("after_fill", 18'h00002, 16'h1234);

        // Backpressure: six back-to-back writes fill the 4-entry FIFO.
        send(3'd3, 24'h000100);
        wait_idle("setptr", 18'h00002, 16'h1234);
        saw_not_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            expect_write(18'h00100 + 18'(i), 16'hA000 + 16'(i), 1'b0, 1'b0);
        end
        for (int i = 0; i < 6; i++) begin
            send(3'd5, 24'h00A000 + 24'(i));
        end
        chk("backpressure_ready_low", 32'(saw_not_ready), 32'd1);
        wait_idle("backpressure", 18'h00105, 16'hA005);

        // Reset in the middle of a 256-word fill with another command queued.
        expect_write(18'h00020, 16'hBEEF, 1'b0, 1'b0);
        expect_write(18'h00021, 16'hBEEF, 1'b0, 1'b0);
        send(3'd3, 24'h000020);
        send(3'd5, 24'h00BEEF);
        send(3'd6, 24'h0000FF);
        send(3'd5, 24'h001111);
        @(negedge clk);
        req_if.req_valid = 1'b0;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!(VRAM_WEb == 1'b0 && VRAM_addr == 18'h00021) && n < 200);
        chk("abort_reach_strobe", 32'(VRAM_WEb), 32'd0);
        abort = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_web", 32'(VRAM_WEb), 32'd1);
        chk("abort_csb", 32'(VRAM_CSb), 32'd1);
        chk("abort_ready", 32'(req_if.req_ready), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_addr", 32'(VRAM_addr), 32'd0);
        chk("abort_pending", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        wr_before = nwrites;
        repeat (40) @(posedge clk);
        #1;
        chk("abort_no_more_writes", 32'(nwrites), 32'(wr_before));
        chk("abort_still_idle", 32'(busy), 32'd0);
        abort = 1'b0;

        // Pointer restarts at zero after reset.
        expect_write(18'h00000, 16'hC0DE, 1'b0, 1'b0);
        send(3'd5, 24'h00C0DE);
        wait_idle("post_reset", 18'h00000, 16'hC0DE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
